// File: rtl/fibonacci_lanes_gen.sv
// Fibonacci term generator emitting LANES consecutive terms per beat
// on a valid/ready stream, with term-count bound and wrap tracking.
module fibonacci_lanes_gen #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       seed0,
  input  logic [WIDTH-1:0]       seed1,
  input  logic [CNT_W-1:0]       count,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   out_last,
  output logic                   out_ovf,
  output logic                   done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a, b;
  logic             wa, wb;
  logic [CNT_W-1:0] rem;

  logic accept, adv, load;

  assign busy   = (state == RUN);
  assign accept = start && (state == IDLE);
  assign adv    = (state == RUN) && out_valid && out_ready;
  assign load   = (accept && count != '0) || (adv && !out_last);

  logic [WIDTH-1:0]       t [LANES+2];
  logic                   w [LANES+2];
  logic [WIDTH:0]         sum;
  logic [CNT_W-1:0]       src_rem;
  logic [CNT_W-1:0]       nxt_rem;
  logic [LANES*WIDTH-1:0] nxt_data;
  logic [LANES-1:0]       nxt_mask;
  logic                   nxt_last;
  logic                   nxt_wrap;

  // t[0..1] are the first two terms of the beat being built; w flags
  // carry the wrap status of a/b, which were computed a beat earlier.
  always_comb begin
    sum      = '0;
    src_rem  = (state == IDLE) ? count : rem;
    t[0]     = (state == IDLE) ? seed0 : a;
    t[1]     = (state == IDLE) ? seed1 : b;
    w[0]     = (state == IDLE) ? 1'b0 : wa;
    w[1]     = (state == IDLE) ? 1'b0 : wb;
    for (int i = 2; i < LANES + 2; i++) begin
      sum  = {1'b0, t[i-1]} + {1'b0, t[i-2]};
      t[i] = sum[WIDTH-1:0];
      w[i] = sum[WIDTH];
    end
    nxt_data = '0;
    nxt_mask = '0;
    nxt_wrap = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (CNT_W'(i) < src_rem) begin
        nxt_data[i*WIDTH +: WIDTH] = t[i];
        nxt_mask[i] = 1'b1;
        nxt_wrap    = nxt_wrap | w[i];
      end
    end
    nxt_last = (src_rem <= CNT_W'(LANES));
    nxt_rem  = nxt_last ? '0 : src_rem - CNT_W'(LANES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      wa        <= 1'b0;
      wb        <= 1'b0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && count == '0) begin
        done    <= 1'b1;
        out_ovf <= 1'b0;
      end
      if (load) begin
        state     <= RUN;
        out_valid <= 1'b1;
        out_data  <= nxt_data;
        out_mask  <= nxt_mask;
        out_last  <= nxt_last;
        out_ovf   <= (accept ? 1'b0 : out_ovf) | nxt_wrap;
        a         <= t[LANES];
        b         <= t[LANES+1];
        wa        <= w[LANES];
        wb        <= w[LANES+1];
        rem       <= nxt_rem;
      end else if (adv) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_mask  <= '0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_lanes_gen.sv
// Bench for fibonacci_lanes_gen: LANES=2 and LANES=3 instances,
// model-built scoreboard plus table of final-beat expectations.
module tb_fibonacci_lanes_gen;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  mask;
    logic        last;
    logic        ovf;
  } exp_t;

  typedef struct {
    bit          sel;
    logic [15:0] s0;
    logic [15:0] s1;
    int          cnt;
    int          stall_beat;
    int          stall_n;
    bit          poke;
    int          nbeats;
    logic [63:0] ldata;
    logic [3:0]  lmask;
    bit          lovf;
  } vec_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        sel = 0;
  logic [15:0] seed0 = 0;
  logic [15:0] seed1 = 0;
  logic [15:0] count = 0;
  logic        out_ready = 1;

  logic        b0, v0, l0, o0, d0;
  logic [31:0] dat0;
  logic [1:0]  m0;
  logic        b1, v1, l1, o1, d1;
  logic [47:0] dat1;
  logic [2:0]  m1;

  logic        x_busy, x_valid, x_last, x_ovf, x_done;
  logic [63:0] x_data;
  logic [3:0]  x_mask;

  always #5 clk = ~clk;

  fibonacci_lanes_gen #(.WIDTH(16), .LANES(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start && !sel),
    .seed0(seed0), .seed1(seed1), .count(count),
    .busy(b0), .out_valid(v0), .out_ready(out_ready),
    .out_data(dat0), .out_mask(m0), .out_last(l0),
    .out_ovf(o0), .done(d0)
  );

  fibonacci_lanes_gen #(.WIDTH(16), .LANES(3), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start && sel),
    .seed0(seed0), .seed1(seed1), .count(count),
    .busy(b1), .out_valid(v1), .out_ready(out_ready),
    .out_data(dat1), .out_mask(m1), .out_last(l1),
    .out_ovf(o1), .done(d1)
  );

  assign x_busy  = sel ? b1 : b0;
  assign x_valid = sel ? v1 : v0;
  assign x_last  = sel ? l1 : l0;
  assign x_ovf   = sel ? o1 : o0;
  assign x_done  = sel ? d1 : d0;
  assign x_data  = sel ? 64'(dat1) : 64'(dat0);
  assign x_mask  = sel ? 4'(m1) : 4'(m0);

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endfunction

  task automatic build(input logic [15:0] s0, input logic [15:0] s1,
                       input int cnt, input int lanes);
    logic [15:0] f[$];
    bit          wr[$];
    logic [16:0] s;
    exp_t        e;
    bit          acc;
    int          n;
    f.push_back(s0);
    f.push_back(s1);
    wr.push_back(1'b0);
    wr.push_back(1'b0);
    for (int k = 2; k < cnt; k++) begin
      s = {1'b0, f[k-1]} + {1'b0, f[k-2]};
      f.push_back(s[15:0]);
      wr.push_back(s[16]);
    end
    acc = 1'b0;
    for (int j = 0; j * lanes < cnt; j++) begin
      e = '0;
      n = cnt - j * lanes;
      if (n > lanes) n = lanes;
      for (int i = 0; i < n; i++) begin
        e.data[i*16 +: 16] = f[j*lanes + i];
        e.mask[i] = 1'b1;
        acc = acc | wr[j*lanes + i];
      end
      e.ovf  = acc;
      e.last = (j * lanes + n == cnt);
      q.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, output int nb, output exp_t lb);
    exp_t e, act;
    int   stalled;
    bit   poked, fin;
    nb = 0;
    lb = '0;
    stalled = 0;
    poked = 0;
    fin = 0;
    q.delete();
    build(v.s0, v.s1, v.cnt, v.sel ? 3 : 2);
    @(negedge clk);
    sel = v.sel;
    seed0 = v.s0;
    seed1 = v.s1;
    count = 16'(v.cnt);
    start = 1;
    out_ready = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (nb == v.stall_beat && stalled < v.stall_n) begin
        out_ready = 0;
        stalled++;
      end else begin
        out_ready = 1;
      end
      if (v.poke && nb == 1 && !poked) begin
        start = 1;
        seed0 = 16'h0099;
        count = 16'd2;
        poked = 1;
      end else begin
        start = 0;
      end
      act = {x_data, x_mask, x_last, x_ovf};
      chk("valid", 64'(x_valid), 64'(1));
      if (x_valid && q.size() > 0) begin
        e = q[0];
        chk("data", act.data, e.data);
        chk("mask", 64'(act.mask), 64'(e.mask));
        chk("last", 64'(act.last), 64'(e.last));
        chk("ovf",  64'(act.ovf),  64'(e.ovf));
        if (out_ready) begin
          void'(q.pop_front());
          nb++;
          lb = act;
          if (e.last) fin = 1;
        end
      end else if (x_valid) begin
        chk("extra_beat", 64'(1), 64'(0));
      end
      @(negedge clk);
    end
    start = 0;
    out_ready = 1;
    if (!fin) begin
      chk("timeout", 64'(0), 64'(1));
    end else begin
      chk("done_pulse", 64'(x_done), 64'(1));
      chk("busy_low", 64'(x_busy), 64'(0));
      chk("valid_low", 64'(x_valid), 64'(0));
      @(negedge clk);
      chk("done_once", 64'(x_done), 64'(0));
    end
  endtask

  vec_t vt[8];
  int   nb;
  exp_t lb;

  initial begin
    vt[0] = '{0, 16'd1, 16'd1, 6, -1, 0, 0, 3, 64'h0008_0005, 4'h3, 0};
    vt[1] = '{0, 16'd1, 16'd1, 5, -1, 0, 0, 3, 64'h0000_0005, 4'h1, 0};
    vt[2] = '{0, 16'd1, 16'd1, 6, 1, 3, 0, 3, 64'h0008_0005, 4'h3, 0};
    vt[3] = '{0, 16'd1, 16'd1, 26, -1, 0, 0, 13, 64'hDA31_2511, 4'h3, 1};
    vt[4] = '{0, 16'd1, 16'd1, 6, -1, 0, 1, 3, 64'h0008_0005, 4'h3, 0};
    vt[5] = '{0, 16'hFFFF, 16'd1, 3, -1, 0, 0, 2, 64'h0, 4'h1, 1};
    vt[6] = '{0, 16'd7, 16'd9, 2, -1, 0, 0, 1, 64'h0009_0007, 4'h3, 0};
    vt[7] = '{1, 16'd0, 16'd1, 7, 0, 2, 0, 3, 64'h8, 4'h1, 0};

    @(negedge clk);
    chk("rst_busy",  64'(x_busy),  64'(0));
    chk("rst_valid", 64'(x_valid), 64'(0));
    chk("rst_data",  x_data,       64'(0));
    chk("rst_mask",  64'(x_mask),  64'(0));
    chk("rst_last",  64'(x_last),  64'(0));
    chk("rst_ovf",   64'(x_ovf),   64'(0));
    chk("rst_done",  64'(x_done),  64'(0));
    rst = 0;

    foreach (vt[i]) begin
      run_vec(vt[i], nb, lb);
      chk("tbl_nbeats", 64'(nb), 64'(vt[i].nbeats));
      chk("tbl_ldata", lb.data, vt[i].ldata);
      chk("tbl_lmask", 64'(lb.mask), 64'(vt[i].lmask));
      chk("tbl_lovf", 64'(lb.ovf), 64'(vt[i].lovf));
      chk("tbl_llast", 64'(lb.last), 64'(1));
    end

    // count == 0: done next cycle, never valid
    @(negedge clk);
    sel = 0;
    count = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("zero_done", 64'(x_done), 64'(1));
    chk("zero_valid", 64'(x_valid), 64'(0));
    chk("zero_busy", 64'(x_busy), 64'(0));
    @(negedge clk);
    chk("zero_done_once", 64'(x_done), 64'(0));
    chk("zero_valid2", 64'(x_valid), 64'(0));

    // reset in the middle of a run
    seed0 = 1;
    seed1 = 1;
    count = 6;
    start = 1;
    @(negedge clk);
    start = 0;
    out_ready = 1;
    @(negedge clk);
    chk("mid_valid", 64'(x_valid), 64'(1));
    chk("mid_beat1", x_data, 64'h0003_0002);
    rst = 1;
    #1;
    chk("mrst_valid", 64'(x_valid), 64'(0));
    chk("mrst_busy",  64'(x_busy),  64'(0));
    chk("mrst_data",  x_data,       64'(0));
    chk("mrst_mask",  64'(x_mask),  64'(0));
    chk("mrst_last",  64'(x_last),  64'(0));
    chk("mrst_done",  64'(x_done),  64'(0));
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("mrst_nodone", 64'(x_done), 64'(0));
    chk("mrst_idle", 64'(x_valid), 64'(0));

    run_vec(vt[0], nb, lb);
    chk("restart_nbeats", 64'(nb), 64'(3));
    chk("restart_ldata", lb.data, 64'h0008_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
